// File: rtl/mvm_pkg.sv
// Shared types and helpers for the column-serial matrix-vector engine.
package mvm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCompute,
    StOut
  } state_e;

  // Accumulator width that cannot overflow a full unsigned dot product of length cols.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned cols);
    return 2 * dw + $clog2(cols);
  endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One output row: operand extension, multiply and wrapping accumulate into acc.
module mvm_mac_lane #(
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             is_signed,
  input  logic [DW-1:0]    w,
  input  logic [DW-1:0]    x,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] prod;

  // Extending both operands to ACC_W first makes the low ACC_W bits of the product
  // equal to the extended 2*DW product, so the add below wraps modulo 2^ACC_W.
  always_comb begin
    w_ext = is_signed ? ACC_W'($signed(w)) : ACC_W'(w);
    x_ext = is_signed ? ACC_W'($signed(x)) : ACC_W'(x);
    prod  = w_ext * x_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod;
    end
  end

endmodule

// File: rtl/mvm_engine.sv
// Matrix-vector engine y = W*x: weight registers, x latch, column FSM and per-row MAC lanes.
module mvm_engine
  import mvm_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int unsigned ACC_W = acc_width(DW, COLS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [ROW_W+COL_W-1:0]  cfg_addr,
  input  logic [DW-1:0]           cfg_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [COLS*DW-1:0]      in_x_flat,
  input  logic                    in_signed,
  input  logic                    in_accum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ROWS*ACC_W-1:0]   out_y_flat,
  output logic                    busy
);

  localparam logic [COL_W-1:0] KLast = COL_W'(COLS - 1);

  state_e           state_q;
  logic [COL_W-1:0] k_q;
  logic             signed_q;
  logic [DW-1:0]    x_q [COLS];
  logic [DW-1:0]    w_q [ROWS][COLS];

  logic             idle;
  logic             accept;
  logic             cfg_hit;
  logic [ROW_W-1:0] cfg_row;
  logic [COL_W-1:0] cfg_col;

  assign idle     = (state_q == StIdle);
  assign cfg_row  = cfg_addr[ROW_W+COL_W-1 -: ROW_W];
  assign cfg_col  = cfg_addr[COL_W-1:0];
  // Out-of-range addresses are dropped without any indication to the host.
  assign cfg_hit  = idle && cfg_valid && (32'(cfg_row) < ROWS) && (32'(cfg_col) < COLS);
  assign accept   = idle && in_valid && !cfg_valid;

  assign cfg_ready = idle;
  assign in_ready  = idle && !cfg_valid;
  assign out_valid = (state_q == StOut);
  assign busy      = !idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      signed_q <= 1'b0;
      for (int k = 0; k < COLS; k++) x_q[k] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            for (int k = 0; k < COLS; k++) x_q[k] <= in_x_flat[k*DW +: DW];
            signed_q <= in_signed;
            k_q      <= '0;
            state_q  <= StCompute;
          end
        end
        StCompute: begin
          if (k_q == KLast) begin
            k_q     <= '0;
            state_q <= StOut;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StOut: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) w_q[r][c] <= '0;
      end
    end else if (cfg_hit) begin
      w_q[cfg_row][cfg_col] <= cfg_data;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    mvm_mac_lane #(
      .DW   (DW),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (accept && !in_accum),
      .en       (state_q == StCompute),
      .is_signed(signed_q),
      .w        (w_q[r][k_q]),
      .x        (x_q[k_q]),
      .acc      (out_y_flat[r*ACC_W +: ACC_W])
    );
  end

endmodule
